// File: rtl/shift_sequencer_if.sv
// Handshake and register-side signals between a shift requester and shift_sequencer.
interface shift_sequencer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int AMT_WIDTH  = 5
);
    logic                  start;
    logic                  dir;
    logic [1:0]            mode;
    logic [AMT_WIDTH-1:0]  amount;
    logic                  abort;
    logic [DATA_WIDTH-1:0] reg_out;
    logic                  sr;
    logic                  sl;
    logic                  ir;
    logic                  il;
    logic                  busy;
    logic                  done;

    modport master (
        output start, dir, mode, amount, abort, reg_out,
        input  sr, sl, ir, il, busy, done
    );

    modport slave (
        input  start, dir, mode, amount, abort, reg_out,
        output sr, sl, ir, il, busy, done
    );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate sequencer driving the serial-shift controls of a register.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; latches dir/mode/effective count
// ST_SHIFT | one sr or sl strobe per cycle, count decrements
// ST_DONE  | one-cycle done pulse, then back to idle
module shift_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int AMT_WIDTH  = 5
) (
    input logic               clk,
    input logic               rst_n,
    shift_sequencer_if.slave  bus
);
    localparam int LW = $clog2(DATA_WIDTH);
    localparam int CW = LW + 1;
    localparam int EW = (AMT_WIDTH > CW) ? AMT_WIDTH : CW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_dir;
    logic [1:0]      r_mode;
    logic            r_busy;
    logic            r_done;

    logic [EW-1:0]   w_amt_ext;
    logic [CW-1:0]   w_cnt_eff;
    logic            w_shift;
    logic            w_ir;
    logic            w_il;

    // Effective count: rotate wraps modulo the width, shifts saturate at the width.
    always_comb begin
        w_amt_ext = EW'(bus.amount);
        w_cnt_eff = '0;
        if (bus.mode == 2'b10) begin
            w_cnt_eff = CW'(w_amt_ext[LW-1:0]);
        end else if (w_amt_ext >= EW'(DATA_WIDTH)) begin
            w_cnt_eff = CW'(DATA_WIDTH);
        end else begin
            w_cnt_eff = CW'(w_amt_ext);
        end
    end

    // Sequencing FSM with registered busy/done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_mode  <= 2'b00;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_dir  <= bus.dir;
                        r_mode <= bus.mode;
                        r_cnt  <= w_cnt_eff;
                        if (w_cnt_eff == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_SHIFT;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_cnt <= r_cnt - CW'(1);
                    // Abort still lets this cycle's strobe land; it only skips done.
                    if (bus.abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (r_cnt == CW'(1)) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Serial-in bits follow the live register value so each shift sees the previous one.
    always_comb begin
        w_shift = (r_state == ST_SHIFT);
        w_ir    = 1'b0;
        w_il    = 1'b0;
        if (w_shift) begin
            case (r_mode)
                2'b01:   w_ir = bus.reg_out[DATA_WIDTH-1];
                2'b10: begin
                    w_ir = bus.reg_out[0];
                    w_il = bus.reg_out[DATA_WIDTH-1];
                end
                default: begin
                    w_ir = 1'b0;
                    w_il = 1'b0;
                end
            endcase
        end
    end

    assign bus.sr   = w_shift & ~r_dir;
    assign bus.sl   = w_shift &  r_dir;
    assign bus.ir   = w_ir;
    assign bus.il   = w_il;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench: shift_sequencer driving a small behavioural 16-bit shift register.
module tb_shift_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld;
    logic [15:0] ld_val;
    logic [15:0] q;

    int n_vec = 0;
    int n_err = 0;
    int n_sr, n_sl, n_ir1, n_il1, n_done, done_cyc, end_cyc;

    always #5 clk = ~clk;

    shift_sequencer_if #(.DATA_WIDTH(16), .AMT_WIDTH(5)) sif ();

    shift_sequencer #(.DATA_WIDTH(16), .AMT_WIDTH(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif)
    );

    // Target register: load beats shifts, as in the real block.
    always @(posedge clk) begin
        if (ld)          q <= ld_val;
        else if (sif.sr) q <= {sif.ir, q[15:1]};
        else if (sif.sl) q <= {q[14:0], sif.il};
    end
    assign sif.reg_out = q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [15:0] v);
        ld = 1'b1;
        ld_val = v;
        @(posedge clk); #1;
        ld = 1'b0;
    endtask

    // Issue one request and watch it to completion; abort_cyc counts SHIFT cycles from 1.
    task automatic run(input logic d, input logic [1:0] m, input logic [4:0] a,
                       input int abort_cyc, input logic noise);
        sif.dir = d; sif.mode = m; sif.amount = a; sif.start = 1'b1;
        @(posedge clk); #1;
        sif.start = noise;
        n_sr = 0; n_sl = 0; n_ir1 = 0; n_il1 = 0; n_done = 0; done_cyc = 0; end_cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            sif.abort = (c == abort_cyc);
            @(negedge clk);
            if (sif.sr) n_sr++;
            if (sif.sl) n_sl++;
            if (sif.sr && sif.ir) n_ir1++;
            if (sif.sl && sif.il) n_il1++;
            if (sif.done) begin
                n_done++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (!sif.busy && !sif.done) begin
                end_cyc = c;
                sif.start = 1'b0;
                sif.abort = 1'b0;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        sif.start = 1'b0;
        sif.abort = 1'b0;
        chk("op_finished", 32'(end_cyc != 0), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; ld = 1'b0; ld_val = '0;
        sif.start = 1'b0; sif.dir = 1'b0; sif.mode = 2'b00; sif.amount = '0; sif.abort = 1'b0;
        #12;
        chk("reset_outputs", 32'({sif.sr, sif.sl, sif.ir, sif.il, sif.busy, sif.done}), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Logical right 3 on 0xF000.
        load(16'hF000);
        run(1'b0, 2'b00, 5'd3, 0, 1'b0);
        chk("lsr3_sr", n_sr, 3);
        chk("lsr3_sl", n_sl, 0);
        chk("lsr3_done_cyc", done_cyc, 4);
        chk("lsr3_done_cnt", n_done, 1);
        chk("lsr3_q", q, 16'h1E00);

        // Arithmetic right 4, negative then positive.
        load(16'h8000);
        run(1'b0, 2'b01, 5'd4, 0, 1'b0);
        chk("asr_neg_ir", n_ir1, 4);
        chk("asr_neg_q", q, 16'hF800);
        load(16'h4000);
        run(1'b0, 2'b01, 5'd4, 0, 1'b0);
        chk("asr_pos_ir", n_ir1, 0);
        chk("asr_pos_q", q, 16'h0400);

        // Rotates, including amount wrap.
        load(16'h1234);
        run(1'b1, 2'b10, 5'd4, 0, 1'b0);
        chk("rol4_sl", n_sl, 4);
        chk("rol4_q", q, 16'h2341);
        load(16'h1234);
        run(1'b0, 2'b10, 5'd20, 0, 1'b0);
        chk("ror20_sr", n_sr, 4);
        chk("ror20_q", q, 16'h4123);
        chk("idle_serial_in", 32'({sif.ir, sif.il}), 32'd0);
        load(16'h8000);
        run(1'b1, 2'b10, 5'd1, 0, 1'b0);
        chk("rol1_il", n_il1, 1);
        chk("rol1_q", q, 16'h0001);

        // Clamped logical left, then zero amount.
        load(16'hFFFF);
        run(1'b1, 2'b00, 5'd31, 0, 1'b0);
        chk("lsl31_sl", n_sl, 16);
        chk("lsl31_done_cyc", done_cyc, 17);
        chk("lsl31_q", q, 16'h0000);
        load(16'hABCD);
        run(1'b0, 2'b00, 5'd0, 0, 1'b0);
        chk("zero_strobes", n_sr + n_sl, 0);
        chk("zero_done_cyc", done_cyc, 1);
        chk("zero_q", q, 16'hABCD);

        // Mode 11 behaves as logical.
        load(16'h8001);
        run(1'b0, 2'b11, 5'd2, 0, 1'b0);
        chk("mode3_q", q, 16'h2000);

        // Abort in the third SHIFT cycle, then a fresh request.
        load(16'hFF00);
        run(1'b0, 2'b00, 5'd8, 3, 1'b0);
        chk("abort_sr", n_sr, 3);
        chk("abort_done", n_done, 0);
        chk("abort_idle_cyc", end_cyc, 4);
        chk("abort_q", q, 16'h1FE0);
        run(1'b0, 2'b00, 5'd1, 0, 1'b0);
        chk("post_abort_done_cyc", done_cyc, 2);
        chk("post_abort_q", q, 16'h0FF0);

        // start held high through SHIFT and DONE must not retrigger or extend.
        load(16'h00F0);
        run(1'b1, 2'b00, 5'd2, 0, 1'b1);
        chk("noise_sl", n_sl, 2);
        chk("noise_done_cnt", n_done, 1);
        chk("noise_done_cyc", done_cyc, 3);
        chk("noise_q", q, 16'h03C0);

        // Asynchronous reset in the middle of a rotate.
        load(16'hFFFF);
        sif.dir = 1'b0; sif.mode = 2'b10; sif.amount = 5'd8; sif.start = 1'b1;
        @(posedge clk); #1;
        sif.start = 1'b0;
        @(posedge clk); #2;
        chk("pre_rst_active", 32'({sif.sr, sif.ir, sif.busy}), 32'b111);
        rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", 32'({sif.sr, sif.sl, sif.ir, sif.il, sif.busy, sif.done}), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", 32'({sif.sr, sif.sl, sif.busy, sif.done}), 32'd0);
        run(1'b0, 2'b00, 5'd0, 0, 1'b0);
        chk("post_rst_zero_done", done_cyc, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
